// File: rtl/reg_bank8_pkg.sv
// Shared sizing constants and types for the eight-entry register bank.
package reg_bank8_pkg;

    localparam int REG_IDX_W      = 3;
    localparam int NUM_REGS       = 8;
    localparam int DATA_W_DEFAULT = 32;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

endpackage

// File: rtl/reg_bank8_wr_decode.sv
// Write-port address decoder: 3-bit index plus enable to a one-hot register select.
module reg_wr_decode
    import reg_bank8_pkg::*;
(
    input  reg_idx_t              idx_i,
    input  logic                  en_i,
    output logic [NUM_REGS-1:0]   onehot_o
);

    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            onehot_o[idx_i] = 1'b1;
        end
    end

endmodule

// File: rtl/reg_bank8.sv
// Eight-entry register bank: one write port, two combinational read ports,
// optional write-through bypass and hard-wired zero register 0.
module reg_bank8
    import reg_bank8_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEFAULT,
    parameter bit          BYPASS  = 1'b1,
    parameter bit          R0_ZERO = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  reg_idx_t          wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  reg_idx_t          rd_addr_a,
    input  reg_idx_t          rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic [7:0]        written,
    output logic [7:0]        wr_count
);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [7:0]          written_q, written_d;
    logic [7:0]          count_q, count_d;
    logic                wr_blocked;
    logic                wr_ok;
    logic [NUM_REGS-1:0] wr_sel;

    // A write is accepted only outside reset and never into a hard-wired zero register 0.
    assign wr_blocked = R0_ZERO && (wr_addr == '0);
    assign wr_ok      = wr_en && !rst && !wr_blocked;

    reg_wr_decode u_wr_decode (
        .idx_i    (wr_addr),
        .en_i     (wr_ok),
        .onehot_o (wr_sel)
    );

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
            if (wr_sel[i]) begin
                regs_d[i] = wr_data;
            end
        end
        written_d = written_q | wr_sel;
        count_d   = count_q;
        if (wr_ok && (count_q != 8'hFF)) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            written_q <= 8'h00;
            count_q   <= 8'h00;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            written_q <= written_d;
            count_q   <= count_d;
        end
    end

    function automatic logic [DATA_W-1:0] read_port(input reg_idx_t addr);
        logic [DATA_W-1:0] val;
        val = regs_q[addr];
        // wr_ok already excludes reset, so bypass shows stored data while rst is high.
        if (BYPASS && wr_ok && (addr == wr_addr)) begin
            val = wr_data;
        end
        if (R0_ZERO && (addr == '0)) begin
            val = '0;
        end
        return val;
    endfunction

    always_comb begin
        rd_data_a = read_port(rd_addr_a);
        rd_data_b = read_port(rd_addr_b);
    end

    assign written  = written_q;
    assign wr_count = count_q;

endmodule
